// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the PC / return-address-stack slice.
package pc_pkg;

    localparam int PC_W_DEF        = 16;
    localparam int BR_IMM_W_DEF    = 6;
    localparam int JMP_IMM_W_DEF   = 12;
    localparam int INSTR_BYTES_DEF = 2;
    localparam int RAS_DEPTH_DEF   = 4;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JUMP   = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4
    } pc_src_e;

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry, a pop of an empty stack is refused.
module ret_addr_stack #(
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk_pi,
    input  logic            reset_pi,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top_data,
    output logic            empty,
    output logic            full,
    output logic            overflow_evt,
    output logic            underflow_evt
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem_r [RAS_DEPTH];
    logic [PTR_W-1:0] sp_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PTR_W-1:0] top_idx_s;
    logic             do_pop_s;
    logic             do_push_s;

    assign top_idx_s     = sp_r - PTR_W'(1);
    assign top_data      = mem_r[top_idx_s];
    assign empty         = (cnt_r == CNT_W'(0));
    assign full          = (cnt_r == CNT_W'(RAS_DEPTH));
    assign do_pop_s      = pop && !empty;
    assign do_push_s     = push && !pop;
    assign overflow_evt  = do_push_s && full;
    assign underflow_evt = pop && empty;

    // Stack pointer and occupancy; occupancy saturates at RAS_DEPTH on overwrite
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            sp_r  <= {PTR_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (do_pop_s) begin
            sp_r  <= top_idx_s;
            cnt_r <= cnt_r - CNT_W'(1);
        end else if (do_push_s) begin
            sp_r  <= sp_r + PTR_W'(1);
            cnt_r <= full ? cnt_r : cnt_r + CNT_W'(1);
        end else begin
            sp_r  <= sp_r;
            cnt_r <= cnt_r;
        end
    end

    // Entry storage; contents are never read while the stack is empty, so no reset
    always_ff @(posedge clk_pi) begin
        if (do_push_s) begin
            mem_r[sp_r] <= push_data;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with relative branch/jump/call, return-address stack and sticky stack error flags.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int BR_IMM_W    = BR_IMM_W_DEF,
    parameter int JMP_IMM_W   = JMP_IMM_W_DEF,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF,
    parameter int RAS_DEPTH   = RAS_DEPTH_DEF
) (
    input  logic                 clk_pi,
    input  logic                 reset_pi,
    input  logic                 clk_en_pi,
    input  logic                 branch_taken_pi,
    input  logic [BR_IMM_W-1:0]  branch_immediate_pi,
    input  logic                 jump_taken_pi,
    input  logic                 call_pi,
    input  logic [JMP_IMM_W-1:0] jump_immediate_pi,
    input  logic                 ret_pi,
    input  logic                 clear_flags_pi,
    output logic [PC_W-1:0]      pc_po,
    output logic                 ras_empty_po,
    output logic                 ras_full_po,
    output logic                 ras_overflow_po,
    output logic                 ras_underflow_po
);

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] seq_s;
    logic [PC_W-1:0] br_tgt_s;
    logic [PC_W-1:0] jmp_tgt_s;
    logic [PC_W-1:0] top_s;
    logic [PC_W-1:0] pc_next_s;
    pc_src_e         src_s;
    logic            push_s;
    logic            pop_s;
    logic            empty_s;
    logic            full_s;
    logic            ovf_evt_s;
    logic            unf_evt_s;
    logic            ovf_r;
    logic            unf_r;

    assign seq_s     = pc_r + PC_W'(INSTR_BYTES);
    assign br_tgt_s  = seq_s + {{(PC_W-BR_IMM_W){branch_immediate_pi[BR_IMM_W-1]}}, branch_immediate_pi};
    assign jmp_tgt_s = seq_s + {{(PC_W-JMP_IMM_W){jump_immediate_pi[JMP_IMM_W-1]}}, jump_immediate_pi};

    // Single-winner source selection so offsets never accumulate
    always_comb begin
        src_s = SEQ;
        if (ret_pi) begin
            src_s = RET;
        end else if (call_pi) begin
            src_s = CALL;
        end else if (jump_taken_pi) begin
            src_s = JUMP;
        end else if (branch_taken_pi) begin
            src_s = BRANCH;
        end else begin
            src_s = SEQ;
        end
    end

    // Next-PC mux; a return with nothing stacked falls through to sequential
    always_comb begin
        pc_next_s = seq_s;
        case (src_s)
            RET:       pc_next_s = empty_s ? seq_s : top_s;
            CALL,
            JUMP:      pc_next_s = jmp_tgt_s;
            BRANCH:    pc_next_s = br_tgt_s;
            SEQ:       pc_next_s = seq_s;
            default:   pc_next_s = seq_s;
        endcase
    end

    assign push_s = clk_en_pi && (src_s == CALL);
    assign pop_s  = clk_en_pi && (src_s == RET);

    ret_addr_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_pi        (clk_pi),
        .reset_pi      (reset_pi),
        .push          (push_s),
        .pop           (pop_s),
        .push_data     (seq_s),
        .top_data      (top_s),
        .empty         (empty_s),
        .full          (full_s),
        .overflow_evt  (ovf_evt_s),
        .underflow_evt (unf_evt_s)
    );

    // Program counter register
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            pc_r <= {PC_W{1'b0}};
        end else if (clk_en_pi) begin
            pc_r <= pc_next_s;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Sticky flags: events only occur when enabled, clear works even while stalled, set beats clear
    always_ff @(posedge clk_pi or posedge reset_pi) begin
        if (reset_pi) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (ovf_evt_s) begin
                ovf_r <= 1'b1;
            end else if (clear_flags_pi) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (unf_evt_s) begin
                unf_r <= 1'b1;
            end else if (clear_flags_pi) begin
                unf_r <= 1'b0;
            end else begin
                unf_r <= unf_r;
            end
        end
    end

    assign pc_po            = pc_r;
    assign ras_empty_po     = empty_s;
    assign ras_full_po      = full_s;
    assign ras_overflow_po  = ovf_r;
    assign ras_underflow_po = unf_r;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit with hand-computed expected values.
module tb_pc_stack_unit;

    logic        clk_pi;
    logic        reset_pi;
    logic        clk_en_pi;
    logic        branch_taken_pi;
    logic [5:0]  branch_immediate_pi;
    logic        jump_taken_pi;
    logic        call_pi;
    logic [11:0] jump_immediate_pi;
    logic        ret_pi;
    logic        clear_flags_pi;
    logic [15:0] pc_po;
    logic        ras_empty_po;
    logic        ras_full_po;
    logic        ras_overflow_po;
    logic        ras_underflow_po;

    int checks_cnt;
    int errors_cnt;

    pc_stack_unit u_dut (
        .clk_pi              (clk_pi),
        .reset_pi            (reset_pi),
        .clk_en_pi           (clk_en_pi),
        .branch_taken_pi     (branch_taken_pi),
        .branch_immediate_pi (branch_immediate_pi),
        .jump_taken_pi       (jump_taken_pi),
        .call_pi             (call_pi),
        .jump_immediate_pi   (jump_immediate_pi),
        .ret_pi              (ret_pi),
        .clear_flags_pi      (clear_flags_pi),
        .pc_po               (pc_po),
        .ras_empty_po        (ras_empty_po),
        .ras_full_po         (ras_full_po),
        .ras_overflow_po     (ras_overflow_po),
        .ras_underflow_po    (ras_underflow_po)
    );

    initial clk_pi = 1'b0;
    always #5 clk_pi = ~clk_pi;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pi);
        #1;
    endtask

    task automatic idle_inputs();
        branch_taken_pi = 1'b0;
        jump_taken_pi   = 1'b0;
        call_pi         = 1'b0;
        ret_pi          = 1'b0;
        clear_flags_pi  = 1'b0;
    endtask

    logic [15:0] ret_exp [4];

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        reset_pi   = 1'b1;
        clk_en_pi  = 1'b1;
        branch_immediate_pi = 6'd0;
        jump_immediate_pi   = 12'd0;
        idle_inputs();
        #2;
        check_val("rst_pc", pc_po, 32'h0);
        check_val("rst_empty", ras_empty_po, 32'h1);
        check_val("rst_full", ras_full_po, 32'h0);
        check_val("rst_flags", {ras_overflow_po, ras_underflow_po}, 32'h0);
        step();
        step();
        reset_pi = 1'b0;

        // sequential advance
        step(); check_val("seq1", pc_po, 32'h2);
        step(); check_val("seq2", pc_po, 32'h4);
        step(); check_val("seq3", pc_po, 32'h6);
        check_val("seq_empty", ras_empty_po, 32'h1);
        for (int i = 0; i < 5; i++) step();
        check_val("seq_0x10", pc_po, 32'h10);

        // branch -2, then branch+jump where jump alone must apply
        branch_taken_pi = 1'b1; branch_immediate_pi = 6'b111110;
        step(); check_val("branch_m2", pc_po, 32'h10);
        jump_taken_pi = 1'b1; jump_immediate_pi = 12'h010;
        step(); check_val("br_jmp_prio", pc_po, 32'h22);
        branch_taken_pi = 1'b0; jump_immediate_pi = 12'h0DC;
        step(); check_val("jump_0x100", pc_po, 32'h100);
        jump_taken_pi = 1'b0;

        // call then ret
        call_pi = 1'b1; jump_immediate_pi = 12'h040;
        step(); check_val("call_pc", pc_po, 32'h142);
        check_val("call_nonempty", ras_empty_po, 32'h0);
        call_pi = 1'b0;
        step(); check_val("seq_after_call", pc_po, 32'h144);
        ret_pi = 1'b1;
        step(); check_val("ret_pc", pc_po, 32'h102);
        check_val("ret_empty", ras_empty_po, 32'h1);
        ret_pi = 1'b0;

        // five calls with zero offset: links 0x104..0x10C, oldest lost
        call_pi = 1'b1; jump_immediate_pi = 12'h000;
        for (int i = 0; i < 4; i++) step();
        check_val("call4_pc", pc_po, 32'h10A);
        check_val("call4_full", ras_full_po, 32'h1);
        check_val("call4_noovf", ras_overflow_po, 32'h0);
        step();
        check_val("call5_pc", pc_po, 32'h10C);
        check_val("call5_full", ras_full_po, 32'h1);
        check_val("call5_ovf", ras_overflow_po, 32'h1);
        call_pi = 1'b0;
        ret_pi  = 1'b1;
        ret_exp[0] = 16'h10C; ret_exp[1] = 16'h10A; ret_exp[2] = 16'h108; ret_exp[3] = 16'h106;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val($sformatf("lifo_ret%0d", i), pc_po, {16'h0, ret_exp[i]});
            if (i == 0) check_val("ret1_notfull", ras_full_po, 32'h0);
        end
        check_val("lifo_empty", ras_empty_po, 32'h1);
        check_val("lifo_no_unf", ras_underflow_po, 32'h0);
        step();
        check_val("ret5_pc", pc_po, 32'h108);
        check_val("ret5_unf", ras_underflow_po, 32'h1);

        // underflow and clear in the same cycle: set wins, overflow clears
        clear_flags_pi = 1'b1;
        step();
        check_val("setwins_pc", pc_po, 32'h10A);
        check_val("setwins_unf", ras_underflow_po, 32'h1);
        check_val("setwins_ovf", ras_overflow_po, 32'h0);
        ret_pi = 1'b0;
        clk_en_pi = 1'b0;
        step();
        check_val("clr_stall_unf", ras_underflow_po, 32'h0);
        check_val("clr_stall_pc", pc_po, 32'h10A);
        clear_flags_pi = 1'b0;

        // stalled call has no effect on PC or stack
        call_pi = 1'b1; jump_immediate_pi = 12'h040;
        step(); step();
        check_val("stall_pc", pc_po, 32'h10A);
        check_val("stall_empty", ras_empty_po, 32'h1);
        call_pi = 1'b0;
        clk_en_pi = 1'b1;
        ret_pi = 1'b1;
        step();
        check_val("stall_nopush_pc", pc_po, 32'h10C);
        check_val("stall_nopush_unf", ras_underflow_po, 32'h1);
        ret_pi = 1'b0;

        // wrap-around: 0x10E - 0x110 = 0xFFFE, then +2 wraps to 0
        jump_taken_pi = 1'b1; jump_immediate_pi = 12'hEF0;
        step(); check_val("jump_fffe", pc_po, 32'hFFFE);
        jump_taken_pi = 1'b0;
        step(); check_val("wrap_0", pc_po, 32'h0);

        // reset pulse between edges discards an in-flight call
        call_pi = 1'b1; jump_immediate_pi = 12'h000;
        step();
        check_val("pre_rst_pc", pc_po, 32'h2);
        check_val("pre_rst_empty", ras_empty_po, 32'h0);
        #2;
        reset_pi = 1'b1;
        #1;
        check_val("async_rst_pc", pc_po, 32'h0);
        check_val("async_rst_empty", ras_empty_po, 32'h1);
        check_val("async_rst_unf", ras_underflow_po, 32'h0);
        #1;
        reset_pi = 1'b0;
        call_pi  = 1'b0;
        step();
        check_val("post_rst_pc", pc_po, 32'h2);
        check_val("post_rst_empty", ras_empty_po, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  PC_W  16  program counter width in bits
  BR_IMM_W  6  branch immediate width, two's complement
  JMP_IMM_W  12  jump/call immediate width, two's complement
  INSTR_BYTES  2  fixed sequential increment
  RAS_DEPTH  4  return-address-stack entries, power of two, >=2
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
  clk_pi  in  1  single clock, rising edge
  reset_pi  in  1  asynchronous, active-high reset
  clk_en_pi  in  1  advance enable; low = stall/halt
  branch_taken_pi  in  1  relative branch
  branch_immediate_pi  in  BR_IMM_W  branch offset
  jump_taken_pi  in  1  relative jump
  call_pi  in  1  relative jump-and-link (uses jump_immediate_pi)
  jump_immediate_pi  in  JMP_IMM_W  jump/call offset
  ret_pi  in  1  return to stacked address
  clear_flags_pi  in  1  clear sticky error flags
  pc_po  out  PC_W  current PC
  ras_empty_po  out  1  stack holds 0 entries
  ras_full_po  out  1  stack holds RAS_DEPTH entries
  ras_overflow_po  out  1  sticky: call while full
  ras_underflow_po  out  1  sticky: ret while empty
REQ-003 Clock SHALL be clk_pi; reset SHALL be reset_pi, asynchronous, active-high.

Function
REQ-004 All state updates SHALL occur on the rising edge of clk_pi when clk_en_pi=1; with clk_en_pi=0, PC, stack and flags SHALL hold, except clear_flags_pi, which SHALL act regardless of clk_en_pi.
REQ-005 seq = PC + INSTR_BYTES; all PC arithmetic SHALL be modulo 2^PC_W (wrap-around, no flag).
REQ-006 Immediates SHALL be sign-extended to PC_W; targets: branch = seq + sext(branch_imm), jump/call = seq + sext(jump_imm).
REQ-007 Next-PC priority, one source per cycle: ret > call > jump > branch > seq; lower-priority requests in the same cycle SHALL be ignored (no cumulative offsets).
REQ-008 call: PC <= jump/call target; seq SHALL be pushed onto the stack in the same cycle.
REQ-009 ret with stack non-empty: PC <= top entry; entry popped same cycle.
REQ-010 ret with stack empty: PC <= seq, stack unchanged, ras_underflow_po set.
REQ-011 call with stack full: oldest entry SHALL be discarded (circular overwrite), new entry pushed, occupancy stays RAS_DEPTH, ras_overflow_po set.
REQ-012 call and ret asserted together: ret SHALL win; no push occurs.
REQ-013 pc_po, ras_empty_po and ras_full_po SHALL be registered/derived from registered state; PC update latency is one cycle.
REQ-014 Sticky flags SHALL remain set until reset or clear_flags_pi=1; if a set condition and clear_flags_pi coincide, set SHALL win.
REQ-015 Occupancy counter SHALL be log2(RAS_DEPTH)+1 bits, saturating at 0 and RAS_DEPTH.

Reset
REQ-016 reset_pi=1 SHALL immediately force PC=0, occupancy=0, stack pointer=0, ras_empty_po=1, ras_full_po=0, both sticky flags=0, independent of clk_pi and clk_en_pi.
REQ-017 Stack entry contents need not be reset; they SHALL be unobservable while empty.
REQ-018 Reset asserted mid-call/ret SHALL discard the operation entirely.

Structure
REQ-019 A shared package pc_pkg SHALL hold default parameter constants and the next-PC source enumeration (SEQ, BRANCH, JUMP, CALL, RET).
REQ-020 The stack SHALL be a sub-module ret_addr_stack (parameters PC_W, RAS_DEPTH; push/pop/data/empty/full/overflow-event/underflow-event).

Verification
REQ-021 Reset then 3 enabled cycles -> pc_po 0, 2, 4, 6; ras_empty_po=1.
REQ-022 PC=0x0010, branch_imm=6'b111110 (-2) -> PC=0x0010; branch+jump (jump_imm=0x010) same cycle -> PC=0x0022 (jump only).
REQ-023 PC=0x0100, call jump_imm=0x040 -> PC=0x0142, top=0x0102; later ret -> PC=0x0102, ras_empty_po=1.
REQ-024 5 calls at DEPTH=4 -> ras_full_po=1, ras_overflow_po=1; 4 rets return the last 4 link addresses in LIFO order; 5th ret -> PC=seq, ras_underflow_po=1.
REQ-025 PC=0xFFFE, enabled cycle -> PC=0x0000; clk_en_pi=0 with call asserted -> no PC or stack change.
REQ-026 reset_pi pulsed between clock edges during a call -> PC=0 and flags/occupancy clear before next edge; clear_flags_pi with clk_en_pi=0 clears sticky flags.
